trace_dump_monitor: RTL and testbench
=====================================

Name: trace_dump_monitor

Overview:
- Synthesizable, parametrised successor to the bench-only halt/register-dump logic that sits beside `cpu`.
- Watches `inst_addr`/`instr` every cycle and counts cycles.
- Detects halt, breakpoint or timeout; on detection it freezes the CPU and serialises the whole register file plus a status record.
- Output is a valid/ready record stream feeding a host UART/FIFO; an optional trace mode emits per-cycle PC records while running.

Parameters:
- W, 32, width of PC, instruction, register data and `out_data`.
- NUM_REGS, 32, number of registers dumped (≥2).
- IDX_W, $clog2(NUM_REGS), register index width.
- HALT_ADDR, 32'hFFFF_FFFF, PC value that signals end of program.
- TIMEOUT, 0, cycle limit before forced halt; 0 = disabled.
- CNT_W, 32, width of the cycle and drop counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  monitor counts/detects only when 1.
- inst_addr  in  W  current CPU PC.
- instr  in  W  current CPU instruction.
- trace_en  in  1  1 = emit PC record every RUN cycle.
- bkpt_en  in  1  breakpoint compare enable.
- bkpt_addr  in  W  breakpoint PC.
- cpu_stall  out  1  freezes CPU PC/regfile writes.
- reg_rd_idx  out  IDX_W  register file read index (combinational read, same-cycle data).
- reg_rd_data  in  W  register file read data.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts record.
- out_tag  out  2  0=PC trace, 1=final PC, 2=REG, 3=STATUS.
- out_idx  out  IDX_W  register index; for STATUS carries halt_cause in bits [1:0].
- out_data  out  W  record payload.
- halted  out  1  dump finished.
- halt_cause  out  2  0=none, 1=HALT_ADDR, 2=breakpoint, 3=timeout.
- cycle_count  out  CNT_W  enabled RUN cycles, saturating.
- trace_drops  out  CNT_W  trace records not accepted, saturating.

Behaviour:
- Reset values:
  - state=RUN.
  - cpu_stall, out_valid, halted = 0.
  - halt_cause, cycle_count, trace_drops, out_tag, out_idx, out_data, reg_rd_idx = 0.
- Reset wins over all events. Reset during DUMP/STATUS aborts the dump, out_valid=0 from the next cycle, and nothing resumes.
- States: RUN -> FINAL_PC -> DUMP -> STATUS -> DONE.
- RUN, enable=1:
  - cycle_count increments, saturating at all-ones.
  - Halt checks each cycle, in priority order: inst_addr==HALT_ADDR (cause 1), then bkpt_en && inst_addr==bkpt_addr (cause 2), then TIMEOUT!=0 && cycle_count==TIMEOUT-1 (cause 3).
  - On a hit:
    - latch inst_addr and halt_cause;
    - cpu_stall=1 from the next cycle, held until reset;
    - next state FINAL_PC.
    - cycle_count includes the halt cycle.
- RUN, enable=0: counters hold, no detection, no trace.
- Trace (RUN, trace_en=1, enable=1):
  - out_valid=1, tag 0, out_data=inst_addr, combinationally in the same cycle.
  - Fire-and-forget: if out_ready=0, trace_drops increments.
  - The halt-hit cycle still emits its trace record.
- FINAL_PC: out_valid=1, tag 1, out_data=latched PC; advance on out_valid&&out_ready.
- DUMP:
  - Index i starts at 0; reg_rd_idx=i.
  - out_valid=1, tag 2, out_idx=i, out_data=reg_rd_data.
  - i advances only on handshake. After i==NUM_REGS-1 is accepted, go to STATUS.
- Handshake rule (FINAL_PC, DUMP, STATUS): while out_valid=1 and out_ready=0, out_tag, out_idx and out_data stay stable. cpu_stall guarantees regfile stability.
- STATUS: out_valid=1, tag 3, out_idx=halt_cause, out_data=cycle_count (zero-extended or truncated to W). On handshake go to DONE.
- DONE: out_valid=0, halted=1, cpu_stall=1, until reset.
- out_ready held high gives back-to-back records, one per cycle.
- Total dump latency from halt detect to halted=1 is NUM_REGS+3 cycles.
- Hits in FINAL_PC/DUMP/STATUS/DONE are ignored; halt_cause is latched once.

Test Plan:
- Program reaches PC=FFFF_FFFF at cycle 10, out_ready=1 -> FINAL_PC record FFFF_FFFF; REG records idx 0..31 back-to-back; STATUS with idx=1 and data=10; halted=1 at halt+35 cycles.
- bkpt_en=1, bkpt_addr=0000_3008, program passes 3008 before reaching HALT_ADDR -> cause 2, final PC 3008, cpu_stall=1 the next cycle.
- Both HALT_ADDR and bkpt_addr equal FFFF_FFFF in the same cycle -> cause 1 (priority).
- TIMEOUT=50, PC never halts -> halt at cycle_count 50, cause 3, STATUS data=50.
- out_ready toggled 1,0,0,1 during DUMP -> each REG record held stable over the stalled cycles; exactly 32 REG records with no repeats or skips.
- trace_en=1, out_ready=0 for 5 RUN cycles -> trace_drops=5; reset asserted mid-DUMP at idx 7 -> next cycle out_valid=0, state RUN, all counters 0.

Source files
------------

// File: rtl/trace_dump_monitor.sv
// rtl/trace_dump_monitor.sv - halt/breakpoint/timeout monitor that freezes the CPU and streams a register dump
module trace_dump_monitor #(
    parameter int             W         = 32,
    parameter int             NUM_REGS  = 32,
    parameter int             IDX_W     = $clog2(NUM_REGS),
    parameter logic [W-1:0]   HALT_ADDR = 32'hFFFF_FFFF,
    parameter int             TIMEOUT   = 0,
    parameter int             CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [W-1:0]     inst_addr,
    input  logic [W-1:0]     instr,
    input  logic             trace_en,
    input  logic             bkpt_en,
    input  logic [W-1:0]     bkpt_addr,
    output logic             cpu_stall,
    output logic [IDX_W-1:0] reg_rd_idx,
    input  logic [W-1:0]     reg_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_tag,
    output logic [IDX_W-1:0] out_idx,
    output logic [W-1:0]     out_data,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] trace_drops
);

    typedef enum logic [2:0] {
        S_RUN,
        S_FINAL_PC,
        S_DUMP,
        S_STATUS,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REGS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     pc_latch;
    logic [IDX_W-1:0] idx;
    logic [1:0]       cause_hit;
    logic             hit;

    // instr is observed but not yet decoded; kept on the port for opcode-based triggers
    logic unused_instr;
    assign unused_instr = ^instr;

    always_comb begin
        cause_hit = 2'd0;
        if (inst_addr == HALT_ADDR)
            cause_hit = 2'd1;
        else if (bkpt_en && (inst_addr == bkpt_addr))
            cause_hit = 2'd2;
        else if ((TIMEOUT != 0) && (cycle_count == TIMEOUT_LAST))
            cause_hit = 2'd3;
    end

    assign hit        = (state == S_RUN) && enable && (cause_hit != 2'd0);
    assign cpu_stall  = (state != S_RUN);
    assign halted     = (state == S_DONE);
    assign reg_rd_idx = idx;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_tag   = 2'd0;
        out_idx   = '0;
        out_data  = '0;
        case (state)
            S_RUN: begin
                if (enable && trace_en) begin
                    out_valid = 1'b1;
                    out_data  = inst_addr;
                end
                if (hit)
                    state_nxt = S_FINAL_PC;
            end
            S_FINAL_PC: begin
                out_valid = 1'b1;
                out_tag   = 2'd1;
                out_data  = pc_latch;
                if (out_ready)
                    state_nxt = S_DUMP;
            end
            S_DUMP: begin
                out_valid = 1'b1;
                out_tag   = 2'd2;
                out_idx   = idx;
                out_data  = reg_rd_data;
                if (out_ready && (idx == LAST_IDX))
                    state_nxt = S_STATUS;
            end
            S_STATUS: begin
                out_valid = 1'b1;
                out_tag   = 2'd3;
                out_idx   = IDX_W'(halt_cause);
                out_data  = W'(cycle_count);
                if (out_ready)
                    state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            pc_latch    <= '0;
            idx         <= '0;
            halt_cause  <= 2'd0;
            cycle_count <= '0;
            trace_drops <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_RUN) && enable) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + CNT_W'(1);
                // trace records are fire-and-forget; a refused one is only counted
                if (trace_en && !out_ready && (trace_drops != '1))
                    trace_drops <= trace_drops + CNT_W'(1);
                if (hit) begin
                    pc_latch   <= inst_addr;
                    halt_cause <= cause_hit;
                end
            end
            if ((state == S_DUMP) && out_ready)
                idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_trace_dump_monitor.sv
// tb/tb_trace_dump_monitor.sv - scoreboard bench for trace_dump_monitor
module tb_trace_dump_monitor;

    typedef struct packed {
        logic [1:0]  tag;
        logic [4:0]  idx;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic        trace_en;
    logic        bkpt_en;
    logic [31:0] bkpt_addr;
    logic        cpu_stall;
    logic [4:0]  reg_rd_idx;
    logic [31:0] reg_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_tag;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic [31:0] trace_drops;

    int   checks = 0;
    int   errors = 0;
    int   reg_accepts = 0;
    rec_t sb_q[$];

    trace_dump_monitor #(.TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .enable(enable), .inst_addr(inst_addr), .instr(instr),
        .trace_en(trace_en), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .cpu_stall(cpu_stall),
        .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .out_idx(out_idx), .out_data(out_data),
        .halted(halted), .halt_cause(halt_cause), .cycle_count(cycle_count),
        .trace_drops(trace_drops)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return 32'h5A00_0000 + {27'd0, i} * 32'h0001_0203;
    endfunction

    function automatic rec_t mk(input logic [1:0] t, input logic [4:0] i, input logic [31:0] d);
        rec_t r;
        r.tag  = t;
        r.idx  = i;
        r.data = d;
        return r;
    endfunction

    assign reg_rd_data = reg_val(reg_rd_idx);
    assign instr       = ~inst_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump(input logic [31:0] fpc, input logic [1:0] cause, input logic [31:0] cnt);
        sb_q.push_back(mk(2'd1, 5'd0, fpc));
        for (int i = 0; i < 32; i++)
            sb_q.push_back(mk(2'd2, 5'(i), reg_val(5'(i))));
        sb_q.push_back(mk(2'd3, {3'd0, cause}, cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; trace_en = 1'b0; bkpt_en = 1'b0;
        bkpt_addr = 32'h0; out_ready = 1'b1; inst_addr = 32'h0;
        step();
        step();
        sb_q.delete();
        reg_accepts = 0;
        reset = 1'b0;
    endtask

    task automatic wait_halted(output int n);
        n = 0;
        while (!halted && n < 400) begin
            step();
            n++;
        end
        chk("halted_reached", halted, 1);
    endtask

    // monitor: every presented record is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record tag=%0d idx=%0d data=%h", out_tag, out_idx, out_data);
            end else begin
                chk("rec_tag", out_tag, sb_q[0].tag);
                chk("rec_data", out_data, sb_q[0].data);
                if (sb_q[0].tag >= 2'd2)
                    chk("rec_idx", out_idx, sb_q[0].idx);
                if (sb_q[0].tag == 2'd2)
                    chk("rd_idx", reg_rd_idx, sb_q[0].idx);
                if (out_ready && sb_q[0].tag == 2'd2)
                    reg_accepts++;
                if (out_ready || sb_q[0].tag == 2'd0)
                    void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int en_n;
        logic done_hit;
        logic [3:0] pat;

        // reset state
        reset = 1'b1; enable = 1'b0; trace_en = 1'b0; bkpt_en = 1'b0;
        bkpt_addr = 32'h0; out_ready = 1'b1; inst_addr = 32'h0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_drops", trace_drops, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rd_idx", reg_rd_idx, 0);

        // halt address reached on the 10th cycle
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            inst_addr = (c == 10) ? 32'hFFFF_FFFF : 32'h1000 + 32'(4 * (c - 1));
            if (c == 10) push_dump(32'hFFFF_FFFF, 2'd1, 32'd10);
            step();
        end
        chk("t1_stall", cpu_stall, 1);
        chk("t1_cycles", cycle_count, 10);
        chk("t1_cause", halt_cause, 1);
        wait_halted(n);
        chk("t1_latency", n, 34);
        chk("t1_reg_count", reg_accepts, 32);
        chk("t1_sb_empty", sb_q.size(), 0);

        // breakpoint with trace enabled
        do_reset();
        enable = 1'b1; trace_en = 1'b1; bkpt_en = 1'b1; bkpt_addr = 32'h0000_3008;
        for (int c = 0; c < 3; c++) begin
            inst_addr = 32'h3000 + 32'(4 * c);
            sb_q.push_back(mk(2'd0, 5'd0, inst_addr));
            if (c == 2) push_dump(32'h3008, 2'd2, 32'd3);
            step();
            if (c == 1) chk("t2_stall_before", cpu_stall, 0);
        end
        chk("t2_stall_after", cpu_stall, 1);
        chk("t2_cause", halt_cause, 2);
        wait_halted(n);
        chk("t2_sb_empty", sb_q.size(), 0);

        // halt address and breakpoint together, with out_ready toggling 1,0,0,1
        do_reset();
        enable = 1'b1; bkpt_en = 1'b1; bkpt_addr = 32'hFFFF_FFFF;
        inst_addr = 32'h0000_0000;
        step();
        inst_addr = 32'hFFFF_FFFF;
        push_dump(32'hFFFF_FFFF, 2'd1, 32'd2);
        step();
        chk("t3_cause", halt_cause, 1);
        pat = 4'b1001;
        n = 0;
        while (!halted && n < 400) begin
            out_ready = pat[n % 4];
            step();
            n++;
        end
        out_ready = 1'b1;
        chk("t3_halted", halted, 1);
        chk("t3_reg_count", reg_accepts, 32);
        chk("t3_sb_empty", sb_q.size(), 0);

        // timeout with a gap of disabled cycles
        do_reset();
        en_n = 0;
        done_hit = 1'b0;
        for (int k = 0; k < 70 && !done_hit; k++) begin
            enable = !(k >= 20 && k < 23);
            inst_addr = 32'h100 + 32'(4 * k);
            if (enable) begin
                en_n++;
                if (en_n == 50) begin
                    push_dump(inst_addr, 2'd3, 32'd50);
                    done_hit = 1'b1;
                end
            end
            step();
            if (k == 22) chk("t4_count_hold", cycle_count, 20);
        end
        enable = 1'b1;
        chk("t4_cycles", cycle_count, 50);
        chk("t4_cause", halt_cause, 3);
        wait_halted(n);
        chk("t4_cycles_frozen", cycle_count, 50);
        chk("t4_sb_empty", sb_q.size(), 0);

        // dropped trace records, then reset in the middle of the dump
        do_reset();
        enable = 1'b1; trace_en = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            inst_addr = 32'h200 + 32'(4 * c);
            sb_q.push_back(mk(2'd0, 5'd0, inst_addr));
            step();
        end
        chk("t6_drops", trace_drops, 5);
        chk("t6_cycles", cycle_count, 5);
        trace_en = 1'b0; out_ready = 1'b1; inst_addr = 32'hFFFF_FFFF;
        push_dump(32'hFFFF_FFFF, 2'd1, 32'd6);
        step();
        n = 0;
        while (!(out_valid && out_tag == 2'd2 && out_idx == 5'd7) && n < 100) begin
            step();
            n++;
        end
        chk("t6_at_idx7", out_idx, 7);
        reset = 1'b1; enable = 1'b0;
        step();
        chk("t6_valid", out_valid, 0);
        chk("t6_stall", cpu_stall, 0);
        chk("t6_halted", halted, 0);
        chk("t6_cycles_clr", cycle_count, 0);
        chk("t6_drops_clr", trace_drops, 0);
        chk("t6_cause_clr", halt_cause, 0);
        sb_q.delete();
        reset = 1'b0;
        step();
        chk("t6_no_resume", out_valid, 0);
        enable = 1'b1; trace_en = 1'b1; inst_addr = 32'h40;
        sb_q.push_back(mk(2'd0, 5'd0, 32'h40));
        step();
        chk("t6_run_cycles", cycle_count, 1);
        enable = 1'b0; trace_en = 1'b0;
        step();
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
